// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the forwarding / hazard-control slice.
//   fwd_sel_e  : per-operand forwarding source (register file, MEM/WB, EX/MEM)
//   mc_state_e : multi-cycle (MUL/DIV) unit occupancy state
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;

endpackage : hazard_pkg

// File: rtl/fwd_sel_lane.sv
// -----------------------------------------------------------------------------
// fwd_sel_lane
// Combinational forwarding select for a single source operand. EX/MEM wins
// over MEM/WB when both stages write the same register; register 0 is never
// forwarded because it is hard-wired to zero.
// Ports:
//   rs           in  source register index of this operand (ID/EX)
//   mem_rd       in  EX/MEM destination
//   mem_regwrite in  EX/MEM writes the register file
//   wb_rd        in  MEM/WB destination
//   wb_regwrite  in  MEM/WB writes the register file
//   sel          out forwarding select (fwd_sel_e encoding)
// -----------------------------------------------------------------------------
module fwd_sel_lane
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output logic [1:0]            sel
);

  fwd_sel_e sel_s;

  // Priority compare: EX/MEM first, then MEM/WB, else register file.
  always_comb begin
    sel_s = FWD_RF;
    if (mem_regwrite && (mem_rd != {REG_ADDR_W{1'b0}}) && (mem_rd == rs)) begin
      sel_s = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != {REG_ADDR_W{1'b0}}) && (wb_rd == rs)) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  assign sel = sel_s;

endmodule : fwd_sel_lane

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding selects for NUM_SRC operands plus hazard control for the 5-stage
// core: one-cycle load-use stall and an occupancy scoreboard for a single
// multi-cycle (MUL/DIV) execution unit.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Defined   -> adds stall_cycles[31:0] (cycles with stall=1) and
//                lu_events[15:0] (rising edges of the load-use hazard);
//                both saturate and clear on reset.
//   Undefined -> ports and counters are absent.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   ex_rs / id_rs         packed source indices of ID/EX and IF/ID
//   id_valid, id_mc       IF/ID holds an instruction / it targets the MC unit
//   ex_rd, ex_memread     ID/EX destination / ID/EX is a load
//   mem_rd, mem_regwrite  EX/MEM destination / write enable
//   wb_rd, wb_regwrite    MEM/WB destination / write enable
//   mc_start, mc_rd       MC op issued from EX this cycle / its destination
//   fwd_sel               per-operand select, operand i at [2i +: 2]
//   stall, flush_ex       hold PC+IF/ID, bubble into ID/EX (identical)
//   mc_busy, mc_done      MC unit occupied / result writes back this cycle
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  ex_rs,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  id_rs,
  input  logic                           id_valid,
  input  logic                           id_mc,
  input  logic [REG_ADDR_W-1:0]          ex_rd,
  input  logic                           ex_memread,
  input  logic [REG_ADDR_W-1:0]          mem_rd,
  input  logic                           mem_regwrite,
  input  logic [REG_ADDR_W-1:0]          wb_rd,
  input  logic                           wb_regwrite,
  input  logic                           mc_start,
  input  logic [REG_ADDR_W-1:0]          mc_rd,
  output logic [2*NUM_SRC-1:0]           fwd_sel,
  output logic                           stall,
  output logic                           flush_ex,
  output logic                           mc_busy,
  output logic                           mc_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                    stall_cycles,
  output logic [15:0]                    lu_events
`endif
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // BUSY spans MC_LAT cycles: the counter runs MC_LAT-1 down to 0.
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(MC_LAT - 1);

  mc_state_e                state_r, state_s;
  logic [CNT_W-1:0]         cnt_r, cnt_s;
  logic [REG_ADDR_W-1:0]    pend_rd_r, pend_rd_s;

  logic lu_match_s;
  logic mc_match_s;
  logic lu_hz_s;
  logic mc_hz_s;
  logic hz_s;

  // ---------------------------------------------------------------------------
  // Forwarding lanes
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_sel_lane #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_lane (
      .rs           (ex_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_sel[2*i +: 2])
    );
  end

  // Compare every IF/ID source against the load destination and the pending MC destination.
  always_comb begin
    lu_match_s = 1'b0;
    mc_match_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lu_match_s = lu_match_s | (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd);
      mc_match_s = mc_match_s | (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == pend_rd_r);
    end
  end

  // Hazard OR-reduction. A new MC op may enter ID during the DONE cycle since
  // the unit can accept a back-to-back issue then.
  always_comb begin
    lu_hz_s = ex_memread && (ex_rd != ZERO_REG) && id_valid && lu_match_s;
    mc_hz_s = id_valid && mc_busy &&
              ((id_mc && (state_r != MC_DONE)) ||
               ((pend_rd_r != ZERO_REG) && mc_match_s));
    hz_s    = lu_hz_s | mc_hz_s;
  end

  assign stall    = hz_s;
  assign flush_ex = hz_s;
  assign mc_busy  = (state_r != MC_IDLE);
  assign mc_done  = (state_r == MC_DONE);

  // Multi-cycle unit next-state; mc_start while BUSY is ignored.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pend_rd_s = pend_rd_r;
    case (state_r)
      MC_IDLE: begin
        if (mc_start) begin
          state_s   = MC_BUSY;
          cnt_s     = CNT_LOAD;
          pend_rd_s = mc_rd;
        end else begin
          state_s   = MC_IDLE;
        end
      end
      MC_BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = MC_DONE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      MC_DONE: begin
        if (mc_start) begin
          state_s   = MC_BUSY;
          cnt_s     = CNT_LOAD;
          pend_rd_s = mc_rd;
        end else begin
          state_s   = MC_IDLE;
        end
      end
      default: begin
        state_s   = MC_IDLE;
        cnt_s     = CNT_ZERO;
        pend_rd_s = ZERO_REG;
      end
    endcase
  end

  // Multi-cycle unit state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= MC_IDLE;
      cnt_r     <= CNT_ZERO;
      pend_rd_r <= ZERO_REG;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pend_rd_r <= pend_rd_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic lu_hz_r;

  // Saturating performance counters; lu_events counts load-use onsets only.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'h0000_0000;
      lu_events    <= 16'h0000;
      lu_hz_r      <= 1'b0;
    end else begin
      lu_hz_r <= lu_hz_s;
      if (hz_s && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'h0000_0001;
      end
      if (lu_hz_s && !lu_hz_r && (lu_events != 16'hFFFF)) begin
        lu_events <= lu_events + 16'h0001;
      end
    end
  end
`endif

endmodule : fwd_hazard_ctrl

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Self-checking bench for fwd_hazard_ctrl built with NUM_SRC=3, MC_LAT=4.
// Combinational forwarding / load-use cases come from a vector table; the
// multi-cycle unit, back-to-back issue and mid-operation reset are covered by
// hand-written cycle sequences. Expected outputs are queued when stimulus is
// driven and popped when the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int RW  = 5;
  localparam int NS  = 3;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*RW-1:0]  ex_rs, id_rs;
  logic              id_valid, id_mc;
  logic [RW-1:0]     ex_rd, mem_rd, wb_rd, mc_rd;
  logic              ex_memread, mem_regwrite, wb_regwrite, mc_start;
  logic [2*NS-1:0]   fwd_sel;
  logic              stall, flush_ex, mc_busy, mc_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       stall_cycles;
  logic [15:0]       lu_events;
`endif

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_ADDR_W (RW),
    .NUM_SRC    (NS),
    .MC_LAT     (LAT),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_rs        (ex_rs),
    .id_rs        (id_rs),
    .id_valid     (id_valid),
    .id_mc        (id_mc),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .mc_start     (mc_start),
    .mc_rd        (mc_rd),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .flush_ex     (flush_ex),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .lu_events    (lu_events)
`endif
  );

  typedef struct {
    string      name;
    logic [9:0] exp;   // {fwd_sel, stall, flush_ex, mc_busy, mc_done}
  } sb_t;

  typedef struct {
    string        name;
    logic [14:0]  ex_rs;
    logic [14:0]  id_rs;
    logic         id_valid;
    logic         ex_memread;
    logic [4:0]   ex_rd;
    logic [4:0]   mem_rd;
    logic         mw;
    logic [4:0]   wb_rd;
    logic         ww;
    logic [5:0]   exp_fs;
    logic         exp_st;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[13];
  int   checks   = 0;
  int   failures = 0;

  // Protocol: mc_start must never be raised while the unit is in BUSY.
  always @(negedge clk) begin
    if (!reset && mc_start && mc_busy && !mc_done)
      $error("protocol: mc_start issued while multi-cycle unit busy");
  end

  function automatic logic [14:0] pk(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] c);
    return {c, b, a};
  endfunction

  function automatic vec_t mk(input string nm, input logic [14:0] ers,
                              input logic [14:0] irs, input logic iv,
                              input logic emr, input logic [4:0] erd,
                              input logic [4:0] mrd, input logic mw,
                              input logic [4:0] wrd, input logic ww,
                              input logic [5:0] fs, input logic st);
    vec_t v;
    v.name = nm; v.ex_rs = ers; v.id_rs = irs; v.id_valid = iv;
    v.ex_memread = emr; v.ex_rd = erd; v.mem_rd = mrd; v.mw = mw;
    v.wb_rd = wrd; v.ww = ww; v.exp_fs = fs; v.exp_st = st;
    return v;
  endfunction

  task automatic clear_in();
    ex_rs = '0; id_rs = '0; id_valid = 1'b0; id_mc = 1'b0;
    ex_rd = '0; ex_memread = 1'b0; mem_rd = '0; mem_regwrite = 1'b0;
    wb_rd = '0; wb_regwrite = 1'b0; mc_start = 1'b0; mc_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [5:0] fs, input logic st,
                            input logic bz, input logic dn);
    sb_t e;
    e.name = nm;
    e.exp  = {fs, st, st, bz, dn};
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    sb_t        e;
    logic [9:0] act;
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {fwd_sel, stall, flush_ex, mc_busy, mc_done};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got {fwd,stall,flush,busy,done}=%b expected %b",
                 e.name, act, e.exp);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();

    tbl[0]  = mk("all_zero",    15'd0,            15'd0,            1'b0, 1'b0, 5'd0, 5'd0,  1'b0, 5'd0,  1'b0, 6'b000000, 1'b0);
    tbl[1]  = mk("mem_over_wb", pk(5'd5,5'd0,5'd0), 15'd0,          1'b0, 1'b0, 5'd0, 5'd5,  1'b1, 5'd5,  1'b1, 6'b000010, 1'b0);
    tbl[2]  = mk("wb_only",     pk(5'd5,5'd0,5'd0), 15'd0,          1'b0, 1'b0, 5'd0, 5'd5,  1'b0, 5'd5,  1'b1, 6'b000001, 1'b0);
    tbl[3]  = mk("mem_rd_zero", pk(5'd5,5'd0,5'd0), 15'd0,          1'b0, 1'b0, 5'd0, 5'd0,  1'b1, 5'd5,  1'b1, 6'b000001, 1'b0);
    tbl[4]  = mk("zero_reg",    15'd0,            15'd0,            1'b0, 1'b0, 5'd0, 5'd0,  1'b1, 5'd0,  1'b1, 6'b000000, 1'b0);
    tbl[5]  = mk("op2_wb",      pk(5'd4,5'd3,5'd12), 15'd0,         1'b0, 1'b0, 5'd0, 5'd20, 1'b1, 5'd12, 1'b1, 6'b010000, 1'b0);
    tbl[6]  = mk("mixed",       pk(5'd6,5'd6,5'd8), 15'd0,          1'b0, 1'b0, 5'd0, 5'd6,  1'b1, 5'd8,  1'b1, 6'b011010, 1'b0);
    tbl[7]  = mk("wb_nowrite",  pk(5'd9,5'd0,5'd0), 15'd0,          1'b0, 1'b0, 5'd0, 5'd0,  1'b0, 5'd9,  1'b0, 6'b000000, 1'b0);
    tbl[8]  = mk("lu_hit",      15'd0, pk(5'd0,5'd7,5'd0),          1'b1, 1'b1, 5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 6'b000000, 1'b1);
    tbl[9]  = mk("lu_rd0",      15'd0, pk(5'd0,5'd7,5'd0),          1'b1, 1'b1, 5'd0, 5'd0,  1'b0, 5'd0,  1'b0, 6'b000000, 1'b0);
    tbl[10] = mk("lu_invalid",  15'd0, pk(5'd0,5'd7,5'd0),          1'b0, 1'b1, 5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 6'b000000, 1'b0);
    tbl[11] = mk("lu_op2",      15'd0, pk(5'd1,5'd2,5'd7),          1'b1, 1'b1, 5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 6'b000000, 1'b1);
    tbl[12] = mk("lu_noload",   15'd0, pk(5'd1,5'd2,5'd7),          1'b1, 1'b0, 5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 6'b000000, 1'b0);

    // Reset state
    tick();
    expect_out("reset_state", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();
    tick();
    reset = 1'b0;

    // Table-driven combinational vectors (MC unit idle)
    for (int i = 0; i < 13; i++) begin
      tick();
      clear_in();
      ex_rs = tbl[i].ex_rs; id_rs = tbl[i].id_rs; id_valid = tbl[i].id_valid;
      ex_memread = tbl[i].ex_memread; ex_rd = tbl[i].ex_rd;
      mem_rd = tbl[i].mem_rd; mem_regwrite = tbl[i].mw;
      wb_rd = tbl[i].wb_rd; wb_regwrite = tbl[i].ww;
      expect_out(tbl[i].name, tbl[i].exp_fs, tbl[i].exp_st, 1'b0, 1'b0);
      check_out();
    end

    // Load-use: one stall cycle, then the bubble removes the dependency
    tick();
    clear_in();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = pk(5'd0, 5'd7, 5'd0); id_valid = 1'b1;
    expect_out("lu_seq_stall", 6'b000000, 1'b1, 1'b0, 1'b0);
    check_out();
    tick();
    ex_memread = 1'b0; ex_rd = 5'd0;
    expect_out("lu_seq_release", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();

    // Multi-cycle op with register dependency on operand 0
    tick();
    clear_in();
    mc_start = 1'b1; mc_rd = 5'd9; id_rs = pk(5'd9, 5'd0, 5'd0); id_valid = 1'b1;
    expect_out("mc_issue", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();
    for (int k = 1; k <= LAT; k++) begin
      tick();
      mc_start = 1'b0;
      expect_out($sformatf("mc_busy_%0d", k), 6'b000000, 1'b1, 1'b1, 1'b0);
      check_out();
    end
    tick();
    expect_out("mc_done", 6'b000000, 1'b1, 1'b1, 1'b1);
    check_out();
    tick();
    expect_out("mc_idle_after", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();

    // id_mc structural stall, then back-to-back issue in DONE
    tick();
    clear_in();
    mc_start = 1'b1; mc_rd = 5'd3; id_rs = pk(5'd1, 5'd2, 5'd4); id_valid = 1'b1; id_mc = 1'b1;
    expect_out("mcs_issue", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();
    for (int k = 1; k <= LAT; k++) begin
      tick();
      mc_start = 1'b0;
      expect_out($sformatf("mcs_busy_%0d", k), 6'b000000, 1'b1, 1'b1, 1'b0);
      check_out();
    end
    tick();
    mc_start = 1'b1; mc_rd = 5'd11;
    expect_out("mcs_done_nostall", 6'b000000, 1'b0, 1'b1, 1'b1);
    check_out();
    for (int k = 1; k <= LAT; k++) begin
      tick();
      mc_start = 1'b0; id_mc = 1'b0; id_rs = pk(5'd0, 5'd11, 5'd0);
      expect_out($sformatf("b2b_busy_%0d", k), 6'b000000, 1'b1, 1'b1, 1'b0);
      check_out();
    end
    tick();
    expect_out("b2b_done", 6'b000000, 1'b1, 1'b1, 1'b1);
    check_out();
    tick();
    expect_out("b2b_idle", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();

    // Reset while BUSY with cnt=2: unit drops to idle, no done pulse
    tick();
    clear_in();
    mc_start = 1'b1; mc_rd = 5'd9; id_rs = pk(5'd9, 5'd0, 5'd0); id_valid = 1'b1;
    check_out();
    tick();
    mc_start = 1'b0;
    expect_out("rst_busy_cnt3", 6'b000000, 1'b1, 1'b1, 1'b0);
    check_out();
    tick();
    reset = 1'b1;
    expect_out("rst_busy_cnt2", 6'b000000, 1'b1, 1'b1, 1'b0);
    check_out();
    tick();
    reset = 1'b0;
    expect_out("rst_to_idle", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      expect_out($sformatf("rst_no_done_%0d", k), 6'b000000, 1'b0, 1'b0, 1'b0);
      check_out();
    end

`ifdef HAZARD_PERF_CNT_EN
    // Three separate load-use events
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      clear_in();
      ex_memread = 1'b1; ex_rd = 5'd7; id_rs = pk(5'd0, 5'd7, 5'd0); id_valid = 1'b1;
      tick();
      clear_in();
    end
    tick();
    checks++;
    if (lu_events !== 16'd3) begin
      failures++;
      $display("FAIL perf_lu_events: got %0d expected 3", lu_events);
    end
    checks++;
    if (stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL perf_stall_cycles: got %0d expected 3", stall_cycles);
    end
`else
    do_reset();
`endif

    // Post-reset state once more
    tick();
    expect_out("final_idle", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fwd_hazard_ctrl
